pc_next_unit: RTL

- Program-counter stage directly downstream of the branch comparator. It consumes the comparator's BrTaken together with the jump controls, and owns the architectural PC register.
- Computes the next PC: sequential, branch, jal or jalr.
- Detects misaligned control-flow targets and redirects to a trap vector.
- Supplies pc_out and pc_plus4 to instruction fetch, the immediate adder and the writeback mux.

---
 rtl/pc_next_unit.sv | 124 ++++++++++++
 1 files changed

// File: rtl/pc_next_unit.sv
// Program-counter stage: picks sequential/branch/jal/jalr next PC and traps misaligned redirects.
// Optional macro PC_BRANCH_STATS_EN adds branch/jump/trap event counters.
module pc_next_unit #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        instr_done,
  input  logic        BrTaken,
  input  logic        Jump,
  input  logic        JumpReg,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_val,
`ifdef PC_BRANCH_STATS_EN
  output logic [31:0] br_count,
  output logic [31:0] br_taken_count,
  output logic [15:0] trap_count,
`endif
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        pc_valid,
  output logic        trap,
  output logic [31:0] trap_epc
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_TRAP} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic        trap_q, trap_d;
  logic [31:0] target;
  logic        advance, redirect, misaligned;

  // JumpReg outranks Jump, which outranks a taken branch.
  always_comb begin
    redirect = JumpReg | Jump | BrTaken;
    if (JumpReg)               target = (rs1_val + imm) & 32'hFFFF_FFFE;
    else if (Jump || BrTaken)  target = pc_q + imm;
    else                       target = pc_q + 32'd4;
    misaligned = redirect && (target[1:0] != 2'b00);
    advance    = (state_q == S_RUN) && !stall && instr_done;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    trap_d  = 1'b0;
    case (state_q)
      S_BOOT: state_d = S_RUN;
      S_RUN: begin
        if (advance) begin
          if (misaligned) begin
            state_d = S_TRAP;
            pc_d    = TRAP_VEC;
            epc_d   = pc_q;
            trap_d  = 1'b1;
          end else begin
            pc_d = target;
          end
        end
      end
      S_TRAP:  state_d = S_RUN;
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_VEC;
      epc_q   <= 32'd0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      trap_q  <= trap_d;
    end
  end

  assign pc_out   = pc_q;
  assign pc_plus4 = pc_q + 32'd4;
  assign pc_valid = (state_q != S_BOOT);
  assign trap     = trap_q;
  assign trap_epc = epc_q;

`ifdef PC_BRANCH_STATS_EN
  logic [31:0] br_count_q, br_count_d;
  logic [31:0] br_taken_count_q, br_taken_count_d;
  logic [15:0] trap_count_q, trap_count_d;

  always_comb begin
    br_count_d       = br_count_q;
    br_taken_count_d = br_taken_count_q;
    trap_count_d     = trap_count_q;
    if (advance) begin
      if (redirect)                       br_count_d       = br_count_q + 32'd1;
      if (BrTaken && !Jump && !JumpReg)   br_taken_count_d = br_taken_count_q + 32'd1;
      if (misaligned)                     trap_count_d     = trap_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_count_q       <= 32'd0;
      br_taken_count_q <= 32'd0;
      trap_count_q     <= 16'd0;
    end else begin
      br_count_q       <= br_count_d;
      br_taken_count_q <= br_taken_count_d;
      trap_count_q     <= trap_count_d;
    end
  end

  assign br_count       = br_count_q;
  assign br_taken_count = br_taken_count_q;
  assign trap_count     = trap_count_q;
`endif

endmodule
